// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single LEGv8 register-file write port, plus the
// per-register pending-write scoreboard used by decode to stall hazardous reads.
module regfile_write_arbiter #(
    parameter int n = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [4:0]   req0_addr,
    input  logic [n-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [4:0]   req1_addr,
    input  logic [n-1:0] req1_data,
    input  logic         rsv_valid,
    input  logic [4:0]   rsv_addr,
    output logic         W,
    output logic [4:0]   DA,
    output logic [n-1:0] D,
    output logic [31:0]  pending,
    output logic         idle
);

    localparam logic [4:0] XZR = 5'd31;

    logic         w_q, w_d;
    logic [4:0]   da_q, da_d;
    logic [n-1:0] d_q, d_d;
    logic [31:0]  pending_q, pending_d;
    logic         last_grant_q, last_grant_d;
    logic         gnt0, gnt1;

    // Grant depends only on valids and last_grant, never on the output stage.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    always_comb begin
        w_d          = 1'b0;
        da_d         = da_q;
        d_d          = d_q;
        last_grant_d = last_grant_q;
        if (gnt0) begin
            w_d          = (req0_addr != XZR);
            da_d         = req0_addr;
            d_d          = req0_data;
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            w_d          = (req1_addr != XZR);
            da_d         = req1_addr;
            d_d          = req1_data;
            last_grant_d = 1'b1;
        end
    end

    // Clear is applied before set so a same-edge reservation of the written register wins.
    always_comb begin
        pending_d = pending_q;
        if (w_q) begin
            pending_d[da_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != XZR)) begin
            pending_d[rsv_addr] = 1'b1;
        end
        pending_d[31] = 1'b0;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            w_q          <= 1'b0;
            da_q         <= '0;
            d_q          <= '0;
            pending_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            w_q          <= w_d;
            da_q         <= da_d;
            d_q          <= d_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign W          = w_q;
    assign DA         = da_q;
    assign D          = d_q;
    assign pending    = pending_q;
    assign idle       = (pending_q == 32'd0) && !w_q;

endmodule
